// File: rtl/spi_master_tx.sv
// SPI mode-0 master: shifts one byte out MSB first per request and captures one byte from MISO.
// The SPI pins and handshake outputs are registered from the sequencer state and trail it by one clock.
module spi_master_tx #(
    parameter int unsigned CLK_DIV = 32'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_en_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic [7:0] rx_data_o,
    output logic       spi_csn_o,
    output logic       spi_clk_o,
    input  logic       spi_miso_i,
    output logic       spi_mosi_o
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [7:0] HP_LAST = 8'(CLK_DIV - 32'd1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] hp_cnt_r;
    logic [3:0] edge_cnt_r;
    logic [7:0] tx_shift_r;
    logic [7:0] rx_shift_r;
    logic [7:0] rx_data_r;
    logic       tx_busy_r;
    logic       tx_done_r;
    logic       spi_csn_r;
    logic       spi_clk_r;
    logic       spi_mosi_r;
    logic       hp_last_s;
    logic       cs_active_s;
    logic       sclk_high_s;
    logic       rise_s;
    logic       shift_s;
    logic       accept_s;

    // Phase decode: even SHIFT phases are the SCLK-high half periods.
    always_comb begin
        hp_last_s   = (hp_cnt_r == HP_LAST);
        cs_active_s = (state_r == ST_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_HOLD);
        sclk_high_s = (state_r == ST_SHIFT) && !edge_cnt_r[0];
        rise_s      = sclk_high_s && (hp_cnt_r == 8'd0);
        shift_s     = sclk_high_s && hp_last_s;
        accept_s    = (state_r == ST_IDLE) && tx_en_i;
    end

    // Next-state logic; every non-idle state lasts whole half periods.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  if (tx_en_i) state_nxt_s = ST_SETUP; else state_nxt_s = ST_IDLE;
            ST_SETUP: if (hp_last_s) state_nxt_s = ST_SHIFT; else state_nxt_s = ST_SETUP;
            ST_SHIFT: if (hp_last_s && (edge_cnt_r == 4'd15)) state_nxt_s = ST_HOLD;
                      else state_nxt_s = ST_SHIFT;
            ST_HOLD:  if (hp_last_s) state_nxt_s = ST_GAP; else state_nxt_s = ST_HOLD;
            ST_GAP:   if (hp_last_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_GAP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Half-period and SCLK-edge counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hp_cnt_r   <= 8'd0;
            edge_cnt_r <= 4'd0;
        end else begin
            if ((state_r == ST_IDLE) || hp_last_s) hp_cnt_r <= 8'd0;
            else                                   hp_cnt_r <= hp_cnt_r + 8'd1;
            if (state_r != ST_SHIFT) edge_cnt_r <= 4'd0;
            else if (hp_last_s)      edge_cnt_r <= edge_cnt_r + 4'd1;
            else                     edge_cnt_r <= edge_cnt_r;
        end
    end

    // Shift registers: TX advances as SCLK falls, RX samples MISO as SCLK is driven high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_shift_r <= 8'h00;
            rx_shift_r <= 8'h00;
        end else if (accept_s) begin
            tx_shift_r <= tx_data_i;
            rx_shift_r <= 8'h00;
        end else begin
            if (shift_s) tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            else         tx_shift_r <= tx_shift_r;
            if (rise_s)  rx_shift_r <= {rx_shift_r[6:0], spi_miso_i};
            else         rx_shift_r <= rx_shift_r;
        end
    end

    // Registered outputs decoded from the current state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spi_csn_r  <= 1'b1;
            spi_clk_r  <= 1'b0;
            spi_mosi_r <= 1'b0;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            spi_csn_r  <= !cs_active_s;
            spi_clk_r  <= sclk_high_s;
            spi_mosi_r <= cs_active_s ? tx_shift_r[7] : 1'b0;
            tx_busy_r  <= (state_r != ST_IDLE);
            tx_done_r  <= (state_r == ST_GAP) && (hp_cnt_r == 8'd0);
            if ((state_r == ST_GAP) && (hp_cnt_r == 8'd0)) rx_data_r <= rx_shift_r;
            else                                           rx_data_r <= rx_data_r;
        end
    end

    assign tx_busy_o  = tx_busy_r;
    assign tx_done_o  = tx_done_r;
    assign rx_data_o  = rx_data_r;
    assign spi_csn_o  = spi_csn_r;
    assign spi_clk_o  = spi_clk_r;
    assign spi_mosi_o = spi_mosi_r;
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: lane 0 runs CLK_DIV=4 against a scripted slave, lane 1 runs CLK_DIV=2 in
// MOSI->MISO loopback. A transfer-level model queues expectations; a monitor checks each lane's pins.
module tb_spi_master_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst = 2'b11;
    logic [1:0] tx_en = 2'b00;
    logic [1:0] tx_busy, tx_done, csn, sclk, mosi;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];
    logic       slave_bit = 1'b0;

    spi_master_tx #(.CLK_DIV(4)) u_dut_div4 (
        .clk_i(clk), .rst_i(rst[0]), .tx_en_i(tx_en[0]), .tx_data_i(tx_data[0]),
        .tx_busy_o(tx_busy[0]), .tx_done_o(tx_done[0]), .rx_data_o(rx_data[0]),
        .spi_csn_o(csn[0]), .spi_clk_o(sclk[0]), .spi_miso_i(slave_bit), .spi_mosi_o(mosi[0])
    );

    spi_master_tx #(.CLK_DIV(2)) u_dut_div2 (
        .clk_i(clk), .rst_i(rst[1]), .tx_en_i(tx_en[1]), .tx_data_i(tx_data[1]),
        .tx_busy_o(tx_busy[1]), .tx_done_o(tx_done[1]), .rx_data_o(rx_data[1]),
        .spi_csn_o(csn[1]), .spi_clk_o(sclk[1]), .spi_miso_i(mosi[1]), .spi_mosi_o(mosi[1])
    );

    typedef struct {
        int         ln;
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
        int         done_at;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] slave_q[$];
    int         free_at [2] = '{0, 0};
    int         total = 0;
    int         bad = 0;

    function automatic int cdiv(input int ln);
        return (ln == 0) ? 4 : 2;
    endfunction

    function automatic int find_exp(input int ln);
        int idx = -1;
        for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].ln == ln) idx = k;
        return idx;
    endfunction

    function automatic int count_lane(input int ln);
        int n = 0;
        for (int k = 0; k < exp_q.size(); k++)
            if (exp_q[k].ln == ln) n++;
        return n;
    endfunction

    task automatic drop_lane(input int ln);
        for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].ln == ln) exp_q.delete(k);
    endtask

    task automatic check(input string nm, input int ln, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s lane%0d: got %0h, expected %0h (cycle %0d)", nm, ln, act, req, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Request a transfer; the model accepts it at the first idle-sampling edge at or after the next one.
    task automatic issue(input int ln, input logic [7:0] tx, input logic [7:0] sb, input bit keep);
        exp_t e;
        e.ln      = ln;
        e.tx      = tx;
        e.rx      = (ln == 0) ? sb : tx;
        e.acc     = (cyc + 1 > free_at[ln]) ? cyc + 1 : free_at[ln];
        e.done_at = e.acc + 1 + 18 * cdiv(ln);
        exp_q.push_back(e);
        if (ln == 0) slave_q.push_back(sb);
        free_at[ln] = e.acc + 1 + 19 * cdiv(ln);
        tx_en[ln]   = 1'b1;
        tx_data[ln] = tx;
        while (cyc < e.acc) wait_cycles(1);
        if (!keep) begin
            tx_en[ln]   = 1'b0;
            tx_data[ln] = 8'($urandom);
        end
    endtask

    task automatic run_lane(input int ln);
        int t0;
        rst[ln]     = 1'b1;
        tx_en[ln]   = 1'b0;
        tx_data[ln] = 8'h00;
        wait_cycles(3);
        rst[ln] = 1'b0;
        wait_cycles(20);
        check("idle_csn", ln, csn[ln], 1);
        check("idle_sclk", ln, sclk[ln], 0);
        check("idle_mosi", ln, mosi[ln], 0);
        check("idle_busy", ln, tx_busy[ln], 0);
        check("idle_done", ln, tx_done[ln], 0);
        check("idle_rx", ln, rx_data[ln], 0);
        free_at[ln] = cyc + 1;

        issue(ln, 8'hA5, 8'h3C, 1'b0);
        issue(ln, 8'h01, 8'h5A, 1'b1);
        issue(ln, 8'hFF, 8'hC4, 1'b0);

        issue(ln, 8'h3B, 8'h81, 1'b0);
        t0 = cyc;
        while (cyc < t0 + 9) wait_cycles(1);
        tx_en[ln]   = 1'b1;
        tx_data[ln] = 8'h55;
        wait_cycles(1);
        tx_en[ln]   = 1'b0;

        issue(ln, 8'hE7, 8'h18, 1'b0);
        t0 = cyc;
        while (cyc < t0 + 30) wait_cycles(1);
        #2 rst[ln] = 1'b1;
        #1;
        check("rst_csn", ln, csn[ln], 1);
        check("rst_sclk", ln, sclk[ln], 0);
        check("rst_busy", ln, tx_busy[ln], 0);
        check("rst_done", ln, tx_done[ln], 0);
        check("rst_rx", ln, rx_data[ln], 0);
        drop_lane(ln);
        wait_cycles(3);
        rst[ln] = 1'b0;
        free_at[ln] = cyc + 1;

        issue(ln, 8'hC3, 8'h6D, 1'b0);
        issue(ln, 8'h96, 8'h2B, 1'b0);
        for (int k = 0; k < 12; k++) begin
            wait_cycles(int'($urandom_range(0, 30)));
            issue(ln, 8'($urandom), 8'($urandom), 1'b0);
        end
        while (cyc < free_at[ln] + 2) wait_cycles(1);
        check("pending", ln, count_lane(ln), 0);
    endtask

    // Slave for lane 0: bit 7 on CSN fall, next bit on each SCLK fall.
    initial begin
        logic       p_csn0 = 1'b1;
        logic       p_sclk0 = 1'b0;
        logic [7:0] sreg = 8'h00;
        forever begin
            @(negedge clk);
            if (rst[0]) begin
                sreg      = 8'h00;
                slave_bit = 1'b0;
            end else if (p_csn0 && !csn[0]) begin
                sreg = 8'h00;
                if (slave_q.size() > 0) sreg = slave_q.pop_front();
                slave_bit = sreg[7];
            end else if (p_sclk0 && !sclk[0]) begin
                sreg      = {sreg[6:0], 1'b0};
                slave_bit = sreg[7];
            end
            p_csn0  = csn[0];
            p_sclk0 = sclk[0];
        end
    end

    // Monitor: measures pin timing per lane and scores each done against the queued expectation.
    initial begin
        logic [1:0] p_csn = 2'b11;
        logic [1:0] p_sclk = 2'b00;
        logic [1:0] p_busy = 2'b00;
        int         low_len [2] = '{0, 0};
        int         hi_len [2] = '{0, 0};
        int         busy_len [2] = '{0, 0};
        int         pulses [2] = '{0, 0};
        logic [7:0] mbits [2] = '{8'h00, 8'h00};
        int         i;
        forever begin
            @(negedge clk);
            for (int ln = 0; ln < 2; ln++) begin
                if (rst[ln]) begin
                    low_len[ln]  = 0;
                    hi_len[ln]   = 0;
                    busy_len[ln] = 0;
                    pulses[ln]   = 0;
                    mbits[ln]    = 8'h00;
                end else begin
                    i = find_exp(ln);
                    if (p_csn[ln] && !csn[ln]) begin
                        check("csn_fall_time", ln, cyc, (i >= 0) ? exp_q[i].acc + 1 : -1);
                        low_len[ln] = 0;
                        pulses[ln]  = 0;
                        mbits[ln]   = 8'h00;
                    end
                    if (!csn[ln]) low_len[ln]++;
                    if (!p_csn[ln] && csn[ln]) check("csn_low_len", ln, low_len[ln], 18 * cdiv(ln));
                    if (!p_sclk[ln] && sclk[ln]) begin
                        if (pulses[ln] == 0)
                            check("sclk_first_rise", ln, cyc,
                                  (i >= 0) ? exp_q[i].acc + 1 + cdiv(ln) : -1);
                        pulses[ln]++;
                        mbits[ln]  = {mbits[ln][6:0], mosi[ln]};
                        hi_len[ln] = 0;
                    end
                    if (sclk[ln]) hi_len[ln]++;
                    if (p_sclk[ln] && !sclk[ln]) check("sclk_high_len", ln, hi_len[ln], cdiv(ln));
                    if (tx_busy[ln]) busy_len[ln]++;
                    if (p_busy[ln] && !tx_busy[ln]) begin
                        check("busy_len", ln, busy_len[ln], 19 * cdiv(ln));
                        busy_len[ln] = 0;
                    end
                    if (tx_done[ln]) begin
                        check("done_expected", ln, int'(i >= 0), 1);
                        if (i >= 0) begin
                            check("done_time", ln, cyc, exp_q[i].done_at);
                            check("rx_data", ln, rx_data[ln], exp_q[i].rx);
                            check("mosi_bits", ln, mbits[ln], exp_q[i].tx);
                            check("sclk_pulses", ln, pulses[ln], 8);
                            check("busy_at_done", ln, tx_busy[ln], 1);
                            exp_q.delete(i);
                        end
                    end
                end
                p_csn[ln]  = csn[ln];
                p_sclk[ln] = sclk[ln];
                p_busy[ln] = tx_busy[ln];
            end
        end
    end

    initial begin
        fork
            run_lane(0);
            run_lane(1);
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
